// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder and the core's load/store controller:
// access width encodings, responder FSM states and load-extension helpers.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        W_WORD = 2'b00,
        W_HALF = 2'b01,
        W_BYTE = 2'b10,
        W_RSVD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int DM_DEPTH_WORDS = 3072;

    function automatic logic [31:0] extend16(input logic [15:0] v, input logic sign);
        return sign ? {{16{v[15]}}, v} : {16'h0000, v};
    endfunction

    function automatic logic [31:0] extend8(input logic [7:0] v, input logic sign);
        return sign ? {{24{v[7]}}, v} : {24'h00_0000, v};
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane steering: byte enables and replicated write data for stores,
// sub-word extraction and extension for loads, and alignment checking.
module dm_lane_unit
    import dm_responder_pkg::*;
(
    input  width_e      width_i,
    input  logic        sign_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Select the addressed half/byte of the read word.
    always_comb begin
        half_s = off_i[1] ? rword_i[31:16] : rword_i[15:0];
        byte_s = rword_i[{off_i, 3'b000} +: 8];
    end

    // Decode lanes per access width; the reserved width yields no enables and no data.
    always_comb begin
        be_o       = 4'b0000;
        wword_o    = 32'h0000_0000;
        rdata_o    = 32'h0000_0000;
        misalign_o = 1'b0;
        case (width_i)
            W_WORD: begin
                be_o       = 4'b1111;
                wword_o    = wdata_i;
                rdata_o    = rword_i;
                misalign_o = (off_i != 2'b00);
            end
            W_HALF: begin
                be_o       = off_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = extend16(half_s, sign_i);
                misalign_o = off_i[0];
            end
            W_BYTE: begin
                be_o       = 4'b0001 << off_i;
                wword_o    = {4{wdata_i[7:0]}};
                rdata_o    = extend8(byte_s, sign_i);
                misalign_o = 1'b0;
            end
            default: begin
                be_o       = 4'b0000;
                wword_o    = 32'h0000_0000;
                rdata_o    = 32'h0000_0000;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, performs it on the
// accept edge, and presents the response LATENCY cycles later until it is taken.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIM  = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_START = 4'(LATENCY - 1);

    logic [31:0]   mem_q [DEPTH_WORDS];
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [AW-1:0] idx_s;
    logic          in_range_s;
    logic          misalign_s;
    logic          err_d;
    logic          accept_s;
    logic [31:0]   rword_s;
    logic [31:0]   ext_s;
    logic [31:0]   wword_s;
    logic [3:0]    be_s;
    logic [31:0]   rdata_d;

    dm_lane_unit u_lane (
        .width_i   (width_e'(req_width)),
        .sign_i    (req_sign),
        .off_i     (req_addr[1:0]),
        .wdata_i   (req_wdata),
        .rword_i   (rword_s),
        .be_o      (be_s),
        .wword_o   (wword_s),
        .rdata_o   (ext_s),
        .misalign_o(misalign_s)
    );

    // Request decode: legality check and the value the response register captures.
    always_comb begin
        idx_s      = req_addr[AW+1:2];
        in_range_s = ({1'b0, req_addr} < ADDR_LIM);
        accept_s   = (state_q == IDLE) && req_valid;
        err_d      = (req_width == W_RSVD) || misalign_s || !in_range_s;
        if (in_range_s) begin
            rword_s = mem_q[idx_s];
        end else begin
            rword_s = 32'h0000_0000;
        end
        if (err_d || req_we) begin
            rdata_d = 32'h0000_0000;
        end else begin
            rdata_d = ext_s;
        end
    end

    // Control FSM with the latency counter and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_START;
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Storage array: cleared by reset, byte-masked write for a legal store on the accept edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (accept_s && req_we && !err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wword_s[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder with hand-computed expectations.
module tb_dm_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_width = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_width(req_width),
        .req_sign (req_sign),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic we, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_width = w; req_sign = s; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic acc_chk(input string tag, input logic we, input logic [1:0] w, input logic s,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        access(we, w, s, a, d, rd, er, lat);
        check_eq({tag, "_rdata"}, rd, exp_rd);
        check_eq({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check_eq({tag, "_lat"}, 32'(lat), 32'(LAT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        int          n;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk) reset = 1'b1;

        acc_chk("st_w10",   1'b1, 2'b00, 1'b0, 32'h10, 32'h8765_4321, 32'h0, 1'b0);
        acc_chk("ld_w10",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h8765_4321, 1'b0);
        acc_chk("st_b13",   1'b1, 2'b10, 1'b0, 32'h13, 32'h1234_56AB, 32'h0, 1'b0);
        acc_chk("ld_bs13",  1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFAB, 1'b0);
        acc_chk("ld_bu13",  1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0000_00AB, 1'b0);
        acc_chk("ld_w10b",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hAB65_4321, 1'b0);
        acc_chk("ld_hs12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF_AB65, 1'b0);
        acc_chk("ld_hu10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000_4321, 1'b0);
        acc_chk("ld_h11",   1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1);
        acc_chk("st_h11",   1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF_FFFF, 32'h0, 1'b1);
        acc_chk("ld_w10c",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hAB65_4321, 1'b0);
        acc_chk("st_h16",   1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_1234, 32'h0, 1'b0);
        acc_chk("st_b14",   1'b1, 2'b10, 1'b0, 32'h14, 32'hEEEE_EE5A, 32'h0, 1'b0);
        acc_chk("ld_w14",   1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 32'h1234_005A, 1'b0);
        acc_chk("st_w3000", 1'b1, 2'b00, 1'b0, 32'h3000, 32'h5555_5555, 32'h0, 1'b1);
        acc_chk("ld_w3000", 1'b0, 2'b00, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1);
        acc_chk("ld_hiadr", 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
        acc_chk("ld_w2ffc", 1'b0, 2'b00, 1'b0, 32'h2FFC, 32'h0, 32'h0, 1'b0);
        acc_chk("st_w2ffc", 1'b1, 2'b00, 1'b0, 32'h2FFC, 32'hCAFE_F00D, 32'h0, 1'b0);
        acc_chk("ld_b2fff", 1'b0, 2'b10, 1'b1, 32'h2FFF, 32'h0, 32'hFFFF_FFCA, 1'b0);
        acc_chk("ld_rsvd",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        acc_chk("st_rsvd",  1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        acc_chk("ld_w12",   1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        acc_chk("ld_w10d",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hAB65_4321, 1'b0);

        // Back-pressure: hold rsp_ready low while a second request waits.
        @(negedge clk);
        req_we = 1'b0; req_width = 2'b00; req_sign = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_width = 2'b10; req_addr = 32'h10;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("bp_lat", 32'(n), 32'(LAT));
        held = rsp_rdata;
        check_eq("bp_rdata", held, 32'hAB65_4321);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_rdata_hold", rsp_rdata, 32'hAB65_4321);
            check_eq("bp_ready_low", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_eq("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);
        check_eq("bp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_eq("bp_second_accepted", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("bp2_lat", 32'(n), 32'(LAT));
        check_eq("bp2_rdata", rsp_rdata, 32'h0000_0021);
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Reset while a store waits for its response.
        @(negedge clk);
        req_we = 1'b1; req_width = 2'b00; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk) reset = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) n++;
        end
        check_eq("mid_rst_no_replay", 32'(n), 32'd0);
        acc_chk("ld_w20_rst", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        acc_chk("ld_w10_rst", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder serving the core's load/store port through a valid/ready request channel and a valid/ready response channel. It replaces the zero-latency data memory so the core can be verified against a memory that stalls. It decodes sub-word widths, generates byte enables, sign- or zero-extends loads and flags illegal accesses. It sits between the core's load/store path and a word-organised storage array.

## Interface
- DEPTH_WORDS, 3072: storage size in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.

- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  2  00 word, 01 half, 10 byte, 11 reserved.
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the lane is taken from the low bits.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected.

## Operation
- FSM states:
  - IDLE: req_ready=1. Moves to WAIT on req_valid.
  - WAIT: counter runs LATENCY-1 down to 0. Moves to RESP when the counter is 0; with LATENCY=1, WAIT lasts one cycle.
  - RESP: rsp_valid=1. Moves to IDLE on rsp_ready.
- Accept edge (IDLE & req_valid):
  - Capture we, width, sign and addr.
  - Run the error check.
  - A legal store commits on this edge.
  - A legal load reads the array on this edge into the response register.
- Error conditions:
  - req_width=11.
  - width word with addr[1:0]≠0.
  - width half with addr[0]≠1'b0 violated, i.e. addr[0]=1.
  - addr ≥ 4*DEPTH_WORDS.
  - On error: no write, rsp_err=1, rsp_rdata=0.
- Store byte enables, indexed by addr[1:0]:
  - word: 1111.
  - half: 0011 at offset 0, 1100 at offset 2.
  - byte: 0001 << addr[1:0].
  - Data lanes: byte lanes get req_wdata[7:0] replicated; half lanes get req_wdata[15:0] replicated.
  - Only enabled bytes change.
- Load extract:
  - word: whole word.
  - half: bits [16*addr[1]+:16].
  - byte: bits [8*addr[1:0]+:8].
  - The extracted value is extended per req_sign to 32 bits.
- The array is word-indexed by addr[31:2]; no wrap-around, since out-of-range addresses are errors.
- Store response: rsp_rdata=0, rsp_err=0.

## Timing
- Reset (reset=0 at an edge):
  - FSM goes to IDLE; counter=0.
  - rsp_rdata=0, rsp_err=0, rsp_valid=0, req_ready=1.
  - Every array word is cleared to 0.
- Reset mid-operation: a pending response is dropped and not replayed; a store already committed at acceptance is wiped by the clear.
- Latency: accept at edge N, rsp_valid high from edge N+LATENCY.
- rsp_valid, rsp_rdata and rsp_err stay stable until the rsp_ready handshake.
- Handshake at edge M gives req_ready=1 from edge M. Maximum throughput is one access per LATENCY+2 cycles.
- req_valid outside IDLE is ignored, since req_ready=0. The requester must hold its request until accepted.
- rsp_ready outside RESP has no effect.
- req_ready and rsp_valid are decoded from the state register only, with no combinational path from the inputs.

## Structure
- Shared package holds:
  - width encodings: W_WORD, W_HALF, W_BYTE, W_RSVD;
  - FSM state enum: IDLE, WAIT, RESP;
  - default DEPTH_WORDS.
- The core's controller uses the same width constants.
- Sub-module dm_lane_unit, purely combinational:
  - inputs: width, sign, addr[1:0], store data, read word;
  - outputs: byte enables, lane-aligned write word, extended load data, misalignment flag.
- The top holds the FSM, counter, capture registers and array.

## Test plan
- Store word 0x8765_4321 to 0x10, then load word from 0x10 → rsp_rdata=0x8765_4321, err=0, rsp_valid exactly LATENCY cycles after acceptance.
- Store byte 0xAB to 0x13, then load byte signed → 0xFFFF_FFAB; load byte unsigned → 0x0000_00AB; load word → 0xAB65_4321.
- Load half signed from 0x12 after the above → 0xFFFF_AB65; load half from 0x11 → err=1, rdata=0, memory unchanged.
- Store word to 0x3000 with DEPTH_WORDS=3072 → err=1, no write. Any access with req_width=11 → err=1.
- Hold rsp_ready=0 for 5 cycles with req_valid held high → response stays stable, req_ready=0 throughout, and the second request is accepted in the cycle after the rsp handshake.
- Assert reset in WAIT after a store to 0x20 → rsp_valid never rises, req_ready=1 after reset, and a load from 0x20 returns 0.
